// File: rtl/csmult_arbiter.sv
// Round-robin front end that time-shares one combinational carry-save multiplier
// among NREQ requesters, with a fixed settle window and a single response channel.

module csmulti_fullbasecell #(
  parameter int bitsize = 8
) (
  input  logic [bitsize-1:0]   a_i,
  input  logic [bitsize-1:0]   b_i,
  output logic [2*bitsize-1:0] p_o
);

  localparam int PW = 2 * bitsize;

  logic [PW-1:0] sum;
  logic [PW-1:0] carry;
  logic [PW-1:0] pp;
  logic [PW-1:0] sum_n;
  logic [PW-1:0] carry_n;

  // Each partial-product row is folded into a redundant sum/carry pair through a
  // row of full adders; only the final merge uses a carry-propagating adder.
  always_comb begin
    sum     = '0;
    carry   = '0;
    pp      = '0;
    sum_n   = '0;
    carry_n = '0;
    for (int i = 0; i < bitsize; i++) begin
      pp                = '0;
      pp[i +: bitsize]  = a_i & {bitsize{b_i[i]}};
      sum_n             = sum ^ carry ^ pp;
      carry_n           = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
      sum               = sum_n;
      carry             = carry_n;
    end
    p_o = sum + carry;
  end

endmodule

module csmult_arbiter #(
  parameter int BITSIZE    = 8,
  parameter int NREQ       = 4,
  parameter int MUL_CYCLES = 2,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*BITSIZE-1:0] req_a_i,
  input  logic [NREQ*BITSIZE-1:0] req_b_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [2*BITSIZE-1:0]    resp_product_o,
  output logic [IDW-1:0]          resp_id_o,
  output logic                    busy_o,
  output logic [15:0]             op_count_o
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_e;

  state_e               state_q;
  logic [IDW-1:0]       last_grant_q;
  logic [IDW-1:0]       id_q;
  logic [IDW-1:0]       resp_id_q;
  logic [BITSIZE-1:0]   a_q;
  logic [BITSIZE-1:0]   b_q;
  logic [CW-1:0]        cnt_q;
  logic [2*BITSIZE-1:0] resp_product_q;
  logic                 resp_valid_q;
  logic                 busy_q;
  logic [15:0]          op_count_q;
  logic [15:0]          op_count_d;

  logic [BITSIZE-1:0]   a_slice [NREQ];
  logic [BITSIZE-1:0]   b_slice [NREQ];
  logic [IDW-1:0]       grant_idx;
  logic [IDW-1:0]       cand;
  logic                 grant_found;
  logic                 accept;
  logic [2*BITSIZE-1:0] mul_p;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_slice[i] = req_a_i[i*BITSIZE +: BITSIZE];
      b_slice[i] = req_b_i[i*BITSIZE +: BITSIZE];
    end
  end

  // Search starts just past the last accepted requester, so a requester that was
  // served goes to the back of the line while refused ones keep their place.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept      = rst_ni && (state_q == IDLE) && grant_found;
  assign req_ready_o = accept ? (NREQ'(1) << grant_idx) : '0;
  assign op_count_d  = op_count_q + 16'd1;

  csmulti_fullbasecell #(
    .bitsize(BITSIZE)
  ) u_mul (
    .a_i(a_q),
    .b_i(b_q),
    .p_o(mul_p)
  );

  // The counter is loaded with the full settle window on accept; the product is
  // sampled on the edge where it reaches one, i.e. MUL_CYCLES edges after accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      last_grant_q   <= IDW'(NREQ - 1);
      a_q            <= '0;
      b_q            <= '0;
      id_q           <= '0;
      cnt_q          <= '0;
      resp_product_q <= '0;
      resp_id_q      <= '0;
      resp_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      op_count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q          <= a_slice[grant_idx];
            b_q          <= b_slice[grant_idx];
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
            cnt_q        <= CW'(MUL_CYCLES);
            busy_q       <= 1'b1;
            state_q      <= MUL;
          end
        end
        MUL: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            resp_product_q <= mul_p;
            resp_id_q      <= id_q;
            resp_valid_q   <= 1'b1;
            state_q        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            op_count_q   <= op_count_d;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_product_o = resp_product_q;
  assign resp_id_o      = resp_id_q;
  assign busy_o         = busy_q;
  assign op_count_o     = op_count_q;

endmodule

// File: tb/tb_csmult_arbiter.sv
// Self-checking bench for csmult_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level round-robin / timing model.

module tb_csmult_arbiter;

  localparam int BITSIZE    = 8;
  localparam int NREQ       = 4;
  localparam int MUL_CYCLES = 2;
  localparam int IDW        = 2;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b1;
  logic [NREQ-1:0]         req_valid_i;
  logic [NREQ-1:0]         req_ready_o;
  logic [NREQ*BITSIZE-1:0] req_a_i;
  logic [NREQ*BITSIZE-1:0] req_b_i;
  logic                    resp_valid_o;
  logic                    resp_ready_i;
  logic [2*BITSIZE-1:0]    resp_product_o;
  logic [IDW-1:0]          resp_id_o;
  logic                    busy_o;
  logic [15:0]             op_count_o;

  logic [BITSIZE-1:0] a_arr [NREQ];
  logic [BITSIZE-1:0] b_arr [NREQ];

  int errors = 0;
  int checks = 0;
  int exp_ops = 0;

  csmult_arbiter #(
    .BITSIZE(BITSIZE),
    .NREQ(NREQ),
    .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_a_i(req_a_i),
    .req_b_i(req_b_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_product_o(resp_product_o),
    .resp_id_o(resp_id_o),
    .busy_o(busy_o),
    .op_count_o(op_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Round-robin rule: first asserted valid after the last accepted index, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_operands(input int r, input logic [BITSIZE-1:0] a, input logic [BITSIZE-1:0] b);
    a_arr[r] = a;
    b_arr[r] = b;
    req_a_i[r*BITSIZE +: BITSIZE] = a;
    req_b_i[r*BITSIZE +: BITSIZE] = b;
  endtask

  task automatic pulse_reset();
    req_valid_i  = '0;
    resp_ready_i = 1'b0;
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) set_operands(i, '0, '0);
    req_valid_i  = '0;
    resp_ready_i = 1'b0;
    #3;
    rst_ni      = 1'b0;
    req_valid_i = '1;
    #1;
    checks++; if (req_ready_o !== '0) begin errors++; $display("[TB] FAIL reset_ready: got %0h expected 0", req_ready_o); end
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %0h expected 0", resp_valid_o); end
    checks++; if (resp_product_o !== '0) begin errors++; $display("[TB] FAIL reset_product: got %0h expected 0", resp_product_o); end
    checks++; if (resp_id_o !== '0) begin errors++; $display("[TB] FAIL reset_id: got %0h expected 0", resp_id_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy_o); end
    checks++; if (op_count_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_op_count: got %0h expected 0", op_count_o); end
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (req_ready_o !== '0) begin errors++; $display("[TB] FAIL post_reset_ready: got %0h expected 0", req_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %0h expected 0", busy_o); end
    exp_ops = 0;
  endtask

  task automatic test_single();
    @(negedge clk_i);
    set_operands(1, 8'hFF, 8'hFF);
    req_valid_i  = 4'b0010;
    resp_ready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL single_ready: got %0h expected 2", req_ready_o); end
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %0h expected 1", busy_o); end
    checks++; if (req_ready_o !== '0) begin errors++; $display("[TB] FAIL single_mul_ready: got %0h expected 0", req_ready_o); end
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_early_t1: got %0h expected 0", resp_valid_o); end
    @(negedge clk_i);
    #1;
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_early_t2: got %0h expected 0", resp_valid_o); end
    @(negedge clk_i);
    #1;
    checks++; if (resp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0h expected 1", resp_valid_o); end
    checks++; if (resp_product_o !== 16'hFE01) begin errors++; $display("[TB] FAIL single_product: got %0h expected fe01", resp_product_o); end
    checks++; if (resp_id_o !== 2'd1) begin errors++; $display("[TB] FAIL single_id: got %0h expected 1", resp_id_o); end
    checks++; if (op_count_o !== 16'd0) begin errors++; $display("[TB] FAIL single_count_early: got %0h expected 0", op_count_o); end
    @(negedge clk_i);
    #1;
    exp_ops++;
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_drop: got %0h expected 0", resp_valid_o); end
    checks++; if (op_count_o !== 16'(exp_ops)) begin errors++; $display("[TB] FAIL single_count: got %0h expected %0h", op_count_o, exp_ops); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_drop: got %0h expected 0", busy_o); end
    resp_ready_i = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_id_q[$];
    logic [15:0] exp_p_q[$];
    int n_acc = 0;
    int n_resp = 0;
    int last_acc = 0;
    int g;
    int exp_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) set_operands(i, BITSIZE'($urandom), BITSIZE'($urandom));
    pulse_reset();
    exp_ops = 0;
    for (int s = 0; s < 40 && n_resp < 5; s++) begin
      @(negedge clk_i);
      req_valid_i  = '1;
      resp_ready_i = 1'b1;
      #1;
      if (req_ready_o !== '0) begin
        g = rr_pick(req_valid_i, exp_last);
        checks++; if (req_ready_o !== (NREQ'(1) << g)) begin errors++; $display("[TB] FAIL rr_grant: got %0h expected %0h", req_ready_o, NREQ'(1) << g); end
        if (n_acc > 0) begin
          checks++; if (s - last_acc !== MUL_CYCLES + 2) begin errors++; $display("[TB] FAIL rr_spacing: got %0d expected %0d", s - last_acc, MUL_CYCLES + 2); end
        end
        exp_id_q.push_back(g);
        exp_p_q.push_back(16'(a_arr[g]) * 16'(b_arr[g]));
        exp_last = g;
        last_acc = s;
        n_acc++;
      end
      if (resp_valid_o === 1'b1) begin
        checks++;
        if (exp_id_q.size() == 0) begin
          errors++; $display("[TB] FAIL rr_spurious: got id %0d with no outstanding request", resp_id_o);
        end else begin
          if (resp_id_o !== IDW'(exp_id_q[0]) || resp_product_o !== exp_p_q[0]) begin
            errors++; $display("[TB] FAIL rr_resp: got id %0d product %0h expected id %0d product %0h", resp_id_o, resp_product_o, exp_id_q[0], exp_p_q[0]);
          end
          void'(exp_id_q.pop_front());
          void'(exp_p_q.pop_front());
        end
        n_resp++;
        exp_ops++;
      end
    end
    @(negedge clk_i);
    req_valid_i = '0;
    checks++; if (n_resp !== 5 || n_acc !== 5) begin errors++; $display("[TB] FAIL rr_count: got %0d accepts %0d responses expected 5 and 5", n_acc, n_resp); end
    resp_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    @(negedge clk_i);
    set_operands(3, 8'h80, 8'h02);
    req_valid_i  = 4'b1000;
    resp_ready_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("[TB] FAIL bp_grant: got %0h expected 8", req_ready_o); end
    @(negedge clk_i);
    req_valid_i = 4'b0001;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      #1;
      seen = (resp_valid_o === 1'b1);
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL bp_timeout: got no response expected one within 10 cycles"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (resp_valid_o !== 1'b1 || resp_product_o !== 16'h0100 || resp_id_o !== 2'd3) begin
        errors++; $display("[TB] FAIL bp_hold: got v=%0h p=%0h id=%0h expected v=1 p=0100 id=3", resp_valid_o, resp_product_o, resp_id_o);
      end
      checks++; if (req_ready_o !== '0) begin errors++; $display("[TB] FAIL bp_ready: got %0h expected 0", req_ready_o); end
      checks++; if (op_count_o !== 16'(exp_ops)) begin errors++; $display("[TB] FAIL bp_count_hold: got %0h expected %0h", op_count_o, exp_ops); end
    end
    @(negedge clk_i);
    resp_ready_i = 1'b1;
    req_valid_i  = '0;
    @(negedge clk_i);
    #1;
    exp_ops++;
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got %0h expected 0", resp_valid_o); end
    checks++; if (op_count_o !== 16'(exp_ops)) begin errors++; $display("[TB] FAIL bp_count: got %0h expected %0h", op_count_o, exp_ops); end
    resp_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [NREQ-1:0] exp_ready;
    logic            exp_rv;
    int              exp_id;
    @(negedge clk_i);
    set_operands(1, 8'h33, 8'h44);
    req_valid_i  = 4'b0010;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = '0;
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || resp_valid_o !== 1'b0 || op_count_o !== 16'h0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got busy=%0h v=%0h cnt=%0h expected all 0", busy_o, resp_valid_o, op_count_o);
    end
    exp_ops = 0;
    set_operands(2, 8'h0C, 8'h0B);
    set_operands(0, 8'h07, 8'h09);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    req_valid_i = 4'b0101;
    for (int s = 0; s < 8; s++) begin
      if (s > 0) @(negedge clk_i);
      #1;
      exp_ready = (s == 0) ? 4'b0001 : (s == 4) ? 4'b0100 : 4'b0000;
      exp_rv    = (s == 3) || (s == 7);
      exp_id    = (s == 3) ? 0 : 2;
      checks++; if (req_ready_o !== exp_ready) begin errors++; $display("[TB] FAIL midrst_ready s%0d: got %0h expected %0h", s, req_ready_o, exp_ready); end
      checks++; if (resp_valid_o !== exp_rv) begin errors++; $display("[TB] FAIL midrst_valid s%0d: got %0h expected %0h", s, resp_valid_o, exp_rv); end
      if (exp_rv) begin
        checks++; if (resp_id_o !== IDW'(exp_id) || resp_product_o !== 16'(a_arr[exp_id]) * 16'(b_arr[exp_id])) begin
          errors++; $display("[TB] FAIL midrst_resp s%0d: got id %0d p %0h expected id %0d", s, resp_id_o, resp_product_o, exp_id);
        end
        exp_ops++;
      end
    end
    @(negedge clk_i);
    req_valid_i  = '0;
    resp_ready_i = 1'b0;
  endtask

  task automatic test_edge_operands();
    int                 tbl_r [3] = '{2, 0, 1};
    logic [BITSIZE-1:0] tbl_a [3] = '{8'h00, 8'h01, 8'hFF};
    logic [BITSIZE-1:0] tbl_b [3] = '{8'hA5, 8'hFF, 8'hFF};
    logic [15:0]        tbl_p [3] = '{16'h0000, 16'h00FF, 16'hFE01};
    bit seen;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk_i);
      set_operands(tbl_r[e], tbl_a[e], tbl_b[e]);
      req_valid_i  = NREQ'(1) << tbl_r[e];
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = '0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk_i);
        #1;
        if (resp_valid_o === 1'b1) begin
          seen = 1'b1;
          checks++; if (resp_product_o !== tbl_p[e] || resp_id_o !== IDW'(tbl_r[e])) begin
            errors++; $display("[TB] FAIL edge_op%0d: got id %0d p %0h expected id %0d p %0h", e, resp_id_o, resp_product_o, tbl_r[e], tbl_p[e]);
          end
        end
      end
      checks++; if (!seen) begin errors++; $display("[TB] FAIL edge_timeout%0d: got no response expected one", e); end
      @(negedge clk_i);
      #1;
      exp_ops++;
      checks++; if (op_count_o !== 16'(exp_ops)) begin errors++; $display("[TB] FAIL edge_count%0d: got %0h expected %0h", e, op_count_o, exp_ops); end
    end
    resp_ready_i = 1'b0;
  endtask

  // Transaction-level model: grant by the round-robin rule while no job is
  // outstanding; a job's response appears MUL_CYCLES+1 samples after its accept.
  task automatic test_random();
    bit          pending = 1'b0;
    int          acc_s = 0;
    int          exp_last = NREQ - 1;
    int          g;
    int          exp_id = 0;
    logic [15:0] exp_prod = '0;
    logic [15:0] exp_cnt = '0;
    logic [NREQ-1:0] exp_ready;
    logic        rv;
    pulse_reset();
    for (int s = 0; s < 400; s++) begin
      @(negedge clk_i);
      req_valid_i = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        set_operands(i, ($urandom_range(0, 7) == 0) ? 8'hFF : BITSIZE'($urandom),
                        ($urandom_range(0, 7) == 0) ? 8'h00 : BITSIZE'($urandom));
      end
      resp_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (op_count_o !== exp_cnt) begin errors++; $display("[TB] FAIL rnd_count s%0d: got %0h expected %0h", s, op_count_o, exp_cnt); end
      checks++; if (busy_o !== pending) begin errors++; $display("[TB] FAIL rnd_busy s%0d: got %0h expected %0h", s, busy_o, pending); end
      if (!pending) begin
        g = rr_pick(req_valid_i, exp_last);
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        checks++; if (req_ready_o !== exp_ready) begin errors++; $display("[TB] FAIL rnd_grant s%0d: got %0h expected %0h", s, req_ready_o, exp_ready); end
        checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_idle_valid s%0d: got %0h expected 0", s, resp_valid_o); end
        if (g >= 0) begin
          pending  = 1'b1;
          acc_s    = s;
          exp_last = g;
          exp_id   = g;
          exp_prod = 16'(a_arr[g]) * 16'(b_arr[g]);
        end
      end else begin
        rv = (s >= acc_s + MUL_CYCLES + 1);
        checks++; if (req_ready_o !== '0) begin errors++; $display("[TB] FAIL rnd_busy_ready s%0d: got %0h expected 0", s, req_ready_o); end
        checks++; if (resp_valid_o !== rv) begin errors++; $display("[TB] FAIL rnd_valid s%0d: got %0h expected %0h", s, resp_valid_o, rv); end
        if (rv) begin
          checks++; if (resp_product_o !== exp_prod || resp_id_o !== IDW'(exp_id)) begin
            errors++; $display("[TB] FAIL rnd_resp s%0d: got id %0d p %0h expected id %0d p %0h", s, resp_id_o, resp_product_o, exp_id, exp_prod);
          end
          if (resp_ready_i) begin
            pending = 1'b0;
            exp_cnt = exp_cnt + 16'd1;
          end
        end
      end
    end
    @(negedge clk_i);
    req_valid_i  = '0;
    resp_ready_i = 1'b1;
    repeat (6) @(negedge clk_i);
    resp_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_cnt;
    bit seen;
    pulse_reset();
    @(negedge clk_i);
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    exp_cnt = 16'hFFFE;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk_i);
      set_operands(1, 8'h12, 8'h34);
      req_valid_i  = 4'b0010;
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = '0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk_i);
        #1;
        seen = (resp_valid_o === 1'b1);
      end
      checks++; if (!seen) begin errors++; $display("[TB] FAIL wrap_timeout%0d: got no response expected one", e); end
      @(negedge clk_i);
      #1;
      exp_cnt = exp_cnt + 16'd1;
      checks++; if (op_count_o !== exp_cnt) begin errors++; $display("[TB] FAIL wrap_count%0d: got %0h expected %0h", e, op_count_o, exp_cnt); end
    end
    resp_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_edge_operands();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csmult_arbiter.md
# csmult_arbiter

Round-robin scheduler that shares one combinational `csmulti_fullbasecell` carry-save multiplier among NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake and holds the multiplier inputs stable for a fixed multicycle settle window. It then registers the product and returns it, tagged with the requester index, on a single shared response channel. It sits between the requesting engines and the multiplier array.

## Interface
- BITSIZE, 8, operand width; passed to the multiplier's `bitsize`.
- NREQ, 4, number of requesters; legal range 2..16.
- MUL_CYCLES, 2, settle cycles allowed for the combinational array; must be ≥1.
- IDW, $clog2(NREQ), requester-index width (derived).
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; one clock, asynchronous and active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit set.
- req_a  input  NREQ*BITSIZE  multiplicand; requester i occupies bits [i*BITSIZE +: BITSIZE].
- req_b  input  NREQ*BITSIZE  multiplier; same packing.
- resp_valid  output  1  product available.
- resp_ready  input  1  consumer accepts product.
- resp_product  output  2*BITSIZE  unsigned product a*b.
- resp_id  output  IDW  index of the requester that issued the product.
- busy  output  1  high in any state other than IDLE.
- op_count  output  16  completed-response counter; wraps at 0xFFFF→0.

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - Grant g is the first set bit of req_valid, searching from last_grant+1 upward with wrap modulo NREQ.
  - req_ready[g] is high combinationally; all other ready bits are 0.
  - If no req_valid bit is set, req_ready is all 0.
  - On an edge where req_valid[g] & req_ready[g]:
    - capture req_a/req_b slice g into a_q/b_q;
    - id_q←g, last_grant←g, cnt←MUL_CYCLES;
    - go to MUL.
- MUL:
  - a_q/b_q drive the multiplier and stay stable; req_ready is all 0.
  - cnt decrements each edge.
  - On the edge where cnt==1:
    - resp_product←multiplier output, resp_id←id_q, resp_valid←1;
    - go to RESP.
- RESP:
  - resp_valid, resp_product and resp_id are held stable; req_ready is all 0.
  - On the edge where resp_ready is high: resp_valid←0, op_count←op_count+1, go to IDLE.
- Arbitration:
  - last_grant changes only on an accepted request.
  - A requester that drops valid before being granted loses nothing and records nothing.
  - A requester that is refused waits; fairness is strict round-robin among asserted valids.
- Arithmetic:
  - Unsigned inputs.
  - Product is exactly 2*BITSIZE bits with no truncation; the multiplier output is used as its low 2*BITSIZE bits.
- Reset (asynchronous, any state):
  - state←IDLE, last_grant←NREQ-1 (requester 0 has first priority);
  - a_q/b_q/id_q/cnt/resp_product/resp_id/op_count←0, resp_valid←0, busy←0.
  - Any operation in flight is discarded and no response is produced for it.
- Simultaneous events:
  - A request arriving during MUL or RESP is not accepted until IDLE.
  - resp_ready while resp_valid is low is ignored.

## Timing
- Reset values: req_ready=0 (all bits), resp_valid=0, resp_product=0, resp_id=0, busy=0, op_count=0.
- Accept edge T → resp_valid high after edge T+MUL_CYCLES.
- With resp_ready tied high:
  - response handshake at edge T+MUL_CYCLES+1;
  - next accept no earlier than edge T+MUL_CYCLES+2, giving a minimum issue period of MUL_CYCLES+2 cycles.
- busy rises after the accept edge and falls after the response-handshake edge.
- req_ready is combinational from req_valid and state; all other outputs are registered.

## Test plan
- Reset: assert rst_n=0 mid-cycle → all outputs 0 immediately; after release with req_valid=0, req_ready stays 0 and busy=0.
- Single request (BITSIZE=8, NREQ=4, MUL_CYCLES=2):
  - stimulus: requester 1, a=0xFF, b=0xFF, accepted at edge T;
  - response: resp_valid rises after T+2 with resp_product=0xFE01 and resp_id=1;
  - with resp_ready high, op_count=1 after T+3.
- Round-robin: all four req_valid held high with resp_ready=1 → grant order 0,1,2,3,0, with accepts spaced 4 cycles apart.
- Backpressure:
  - stimulus: resp_ready low for 5 cycles in RESP with product 0x0100 (0x80*0x02) for requester 3;
  - response: resp_valid, product and id hold stable, req_ready stays all 0, op_count does not increment until the handshake.
- Reset mid-operation:
  - stimulus: rst_n pulsed low during MUL, then requesters 2 and 0 valid;
  - response: no response for the discarded op; requester 0 is granted first after release.
- Edge operands:
  - 0x00*0xA5 → 0x0000;
  - 0x01*0xFF → 0x00FF;
  - 65536 completed ops → op_count wraps to 0.
